// File: rtl/ct_byte_streamer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : ct_byte_streamer                                            |
// | Description : Reads the encrypter's ciphertext output memory in address   |
// |               order and presents it as a valid/ready byte stream with a   |
// |               last-byte flag. A small prefetch FIFO hides the two-cycle   |
// |               read latency so back-pressure never drops or repeats bytes. |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module ct_byte_streamer #(
  parameter int N_BYTES = 1088,
  parameter int AW      = 11,
  parameter int DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_do,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last
);

  // Pointer, FIFO-count, occupancy and byte-counter widths.
  localparam int C_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CW = C_PW + 1;
  localparam int C_OW = C_CW + 1;
  localparam int C_NW = $clog2(N_BYTES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [C_NW-1:0] C_LAST_IDX = C_NW'(N_BYTES - 1);
  localparam logic [C_NW-1:0] C_TOTAL    = C_NW'(N_BYTES);
  localparam logic [C_OW-1:0] C_DEPTH    = C_OW'(DEPTH);

  // Control state.
  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic            r_done;

  // Read side: current address, number of addresses placed on mem_addr so
  // far, and a two-stage tag pipeline. r_p1 marks that mem_addr holds an
  // address the RAM samples at the next edge; r_p2 marks that mem_do carries
  // valid data to be captured at the next edge.
  logic [AW-1:0]   r_addr;
  logic [C_NW-1:0] r_issue_cnt;
  logic            r_p1;
  logic            r_p2;

  // Prefetch FIFO and output-side byte index (drives m_last).
  logic [7:0]      r_fifo [DEPTH];
  logic [C_PW-1:0] r_wr_ptr;
  logic [C_PW-1:0] r_rd_ptr;
  logic [C_CW-1:0] r_count;
  logic [C_NW-1:0] r_out_cnt;

  logic            w_start_ok;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic            w_last_pop;
  logic [C_OW-1:0] w_occ;

  // Handshake, occupancy and issue decisions for this cycle.
  always_comb begin
    w_empty    = (r_count == '0);
    w_pop      = ~w_empty & m_ready;
    w_push     = r_p2;
    // start is ignored while busy, including the done cycle.
    w_start_ok = (r_state == S_IDLE) & start & ~r_done;
    // Entries held or still on their way, net of the byte leaving this edge.
    w_occ      = C_OW'(r_count) + C_OW'(r_p1) + C_OW'(r_p2) - C_OW'(w_pop);
    w_issue    = (r_state == S_RUN) & (r_issue_cnt < C_TOTAL) & (w_occ < C_DEPTH);
    w_last_pop = w_pop & (r_out_cnt == C_LAST_IDX);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decision.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        // Leave once every address has been placed on mem_addr.
        if ((r_issue_cnt == C_TOTAL) || (w_issue && (r_issue_cnt == C_LAST_IDX))) begin
          w_next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_last_pop) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode; m_data is forced to zero while the FIFO is empty.
  always_comb begin
    busy     = (r_state != S_IDLE) | r_done;
    done     = r_done;
    mem_addr = r_addr;
    m_valid  = ~w_empty;
    m_data   = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    m_last   = ~w_empty & (r_out_cnt == C_LAST_IDX);
  end

  // Read pipeline, FIFO bookkeeping, byte counter and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done      <= 1'b0;
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_p1        <= 1'b0;
      r_p2        <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_cnt   <= '0;
    end else begin
      r_done <= (r_state == S_FLUSH) & w_last_pop;
      if (w_start_ok) begin
        // Address 0 goes out on the start edge; the RAM samples it next edge.
        r_addr      <= '0;
        r_issue_cnt <= C_NW'(1);
        r_p1        <= 1'b1;
        r_p2        <= 1'b0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_out_cnt   <= '0;
      end else begin
        r_p2 <= r_p1;
        r_p1 <= w_issue;
        if (w_issue) begin
          r_addr      <= r_addr + AW'(1);
          r_issue_cnt <= r_issue_cnt + C_NW'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + C_PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr  <= r_rd_ptr + C_PW'(1);
          r_out_cnt <= r_out_cnt + C_NW'(1);
        end
        r_count <= r_count + C_CW'(w_push) - C_CW'(w_pop);
      end
    end
  end

  // FIFO storage: capture the RAM byte whose read was sampled last edge.
  always_ff @(posedge clk) begin
    if (w_push && !w_start_ok) begin
      r_fifo[r_wr_ptr] <= mem_do;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ct_byte_streamer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_ct_byte_streamer                                         |
// | Description : Self-checking bench for ct_byte_streamer. A synchronous     |
// |               RAM model feeds the DUT; a behavioural model of the stream  |
// |               (byte index, busy/done timing) is compared every cycle.     |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_ct_byte_streamer;

  localparam int N     = 1088;
  localparam int AW    = 11;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_do;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  logic [7:0]    mem [N];

  int n_checks = 0;
  int n_errors = 0;

  // Ready pattern: 0 always high, 1 toggle, 2 random 30% low, 3 stall at byte 10.
  int mode      = 0;
  int stall_cnt = 0;

  // Behavioural stream model.
  bit         active    = 1'b0;
  bit         pend_done = 1'b0;
  int         cyc       = 0;
  int         hs        = 0;
  int         done_cnt  = 0;
  int         last_cnt  = 0;
  int         first_valid_cyc = -1;
  logic [7:0] first_byte = 8'h00;
  logic [7:0] last_byte  = 8'h00;

  ct_byte_streamer #(.N_BYTES(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_do   (mem_do),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  // Encrypter output port: byte data one cycle after the address is sampled.
  always @(posedge clk) mem_do <= mem[mem_addr];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer ready driver.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        2: m_ready = ($urandom_range(0, 99) >= 30);
        default: begin
          if (active && hs >= 10 && stall_cnt < 50) begin
            m_ready = 1'b0;
            stall_cnt++;
          end else begin
            m_ready = 1'b1;
          end
        end
      endcase
      if (mode != 3) stall_cnt = 0;
    end
  end

  // Compare process: DUT outputs against the stream model every cycle.
  always @(negedge clk) begin
    bit exp_valid;
    if (rst) begin
      active    = 1'b0;
      pend_done = 1'b0;
      hs        = 0;
      cyc       = 0;
    end else begin
      // Once byte 0 lands, the FIFO never runs dry before the last byte.
      exp_valid = active && !pend_done && (cyc >= 2) && (hs < N);
      chk1("busy", busy, active);
      chk1("done", done, pend_done);
      chk1("m_valid", m_valid, exp_valid);
      if (exp_valid) begin
        chkv("m_data", int'(m_data), int'(mem[hs]));
        chk1("m_last", m_last, hs == N - 1);
      end else begin
        chk1("m_last_idle", m_last, 1'b0);
      end
      chk1("mem_addr_range", int'(mem_addr) <= N - 1, 1'b1);
      if (active && !pend_done)
        chk1("occupancy", (int'(mem_addr) + 1 - hs) <= DEPTH, 1'b1);
      if (active && cyc == 0)
        chkv("mem_addr_start", int'(mem_addr), 0);
      if (mode == 3 && !m_ready && stall_cnt >= 8)
        chkv("stall_addr", int'(mem_addr), 10 + DEPTH - 1);

      if (done) done_cnt++;
      if (m_valid && first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
        first_byte      = m_data;
      end
      if (m_valid && m_ready && m_last) begin
        last_cnt++;
        last_byte = m_data;
      end

      if (pend_done) begin
        active    = 1'b0;
        pend_done = 1'b0;
      end else if (active) begin
        if (exp_valid && m_ready) begin
          hs++;
          if (hs == N) pend_done = 1'b1;
        end
        cyc++;
      end else if (start) begin
        active          = 1'b1;
        cyc             = 0;
        hs              = 0;
        last_cnt        = 0;
        first_valid_cyc = -1;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int k = 0;
    while (hs < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk1("wait_hs_timeout", hs >= target, 1'b1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk1("wait_done_timeout", done_cnt >= target, 1'b1);
  endtask

  task automatic run_xfer(input int m, input bit ident);
    int d0;
    mode = m;
    d0   = done_cnt;
    pulse_start();
    wait_done(d0 + 1, 20000);
    repeat (2) @(negedge clk);
    #1;
    chk1("busy_after", busy, 1'b0);
    chkv("done_count", done_cnt - d0, 1);
    chkv("last_count", last_cnt, 1);
    chkv("bytes_total", hs, N);
    chkv("first_latency", first_valid_cyc, 2);
    if (ident) begin
      chkv("first_byte", int'(first_byte), 8'h00);
      chkv("last_byte", int'(last_byte), 8'h3F);
    end
  endtask

  initial begin
    int d0;
    int k;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = i[7:0];

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_m_last", m_last, 1'b0);
    chkv("rst_m_data", int'(m_data), 0);
    chkv("rst_mem_addr", int'(mem_addr), 0);
    @(posedge clk); #2 rst = 1'b0;

    run_xfer(0, 1'b1);
    run_xfer(1, 1'b1);
    run_xfer(2, 1'b1);
    run_xfer(3, 1'b1);

    // start while busy is ignored.
    mode = 0;
    d0   = done_cnt;
    pulse_start();
    wait_hs(500, 2000);
    pulse_start();
    wait_done(d0 + 1, 5000);
    repeat (3) @(negedge clk);
    #1;
    chkv("restart_done_count", done_cnt - d0, 1);
    chkv("restart_bytes", hs, N);

    // Asynchronous reset mid-transfer, then a clean replay.
    mode = 2;
    pulse_start();
    wait_hs(300, 3000);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    chk1("arst_m_valid", m_valid, 1'b0);
    chk1("arst_m_last", m_last, 1'b0);
    chkv("arst_m_data", int'(m_data), 0);
    chkv("arst_mem_addr", int'(mem_addr), 0);
    @(posedge clk); #2 rst = 1'b0;
    run_xfer(0, 1'b1);

    // Back-to-back: start held through the done cycle and the cycle after.
    mode = 2;
    d0   = done_cnt;
    pulse_start();
    k = 0;
    while (!done && k < 10000) begin
      @(negedge clk); #1;
      k++;
    end
    chk1("b2b_done_seen", done, 1'b1);
    chkv("b2b_first_last_count", last_cnt, 1);
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(d0 + 2, 10000);
    repeat (2) @(negedge clk);
    #1;
    chkv("b2b_done_count", done_cnt - d0, 2);
    chkv("b2b_last_count", last_cnt, 1);
    chkv("b2b_bytes", hs, N);
    chk1("b2b_busy_after", busy, 1'b0);

    // Random ciphertext content under random back-pressure.
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    run_xfer(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
